// File: rtl/ext_obi_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_obi_rr_arbiter_pkg
// Description : OBI request/response types and shared constants for the
//               external-bus round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_obi_rr_arbiter_pkg;

  // OBI address-phase request from a master
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  // OBI grant and response-phase signals back to a master
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Outstanding-transaction limit used when the arbiter is placed at top level
  localparam int unsigned EXT_ARB_MAX_OUTSTANDING = 2;

  // Index width that stays at least one bit wide for a single master
  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ext_obi_resp_route_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ext_obi_resp_route_fifo
// Description : Synchronous FIFO of master indices. One entry per accepted
//               address phase; the head tells which master owns the next
//               response.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_obi_resp_route_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (r_cnt == CNT_W'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign head_o  = r_mem[r_rd_ptr];
  assign cnt_o   = r_cnt;

  // Full blocks pushes even when a pop happens in the same cycle (no bypass)
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  // Storage, pointers and occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ext_obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ext_obi_rr_arbiter
// Description : N-to-1 OBI arbiter. Round-robin address-phase arbitration
//               with request locking until grant, and in-order routing of
//               responses back to the issuing master.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_obi_rr_arbiter
  import ext_obi_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned MAX_OUTSTANDING = EXT_ARB_MAX_OUTSTANDING
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  obi_req_t  [NUM_MASTERS-1:0] master_req_i,
  output obi_resp_t [NUM_MASTERS-1:0] master_resp_o,
  output obi_req_t                    slave_req_o,
  input  obi_resp_t                   slave_resp_i,
  output logic                        busy_o,
  output logic                        proto_err_o
);

  localparam int unsigned IDX_WIDTH = idx_width(NUM_MASTERS);
  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_WIDTH-1:0] r_rr_ptr;
  logic                 r_lock;
  logic [IDX_WIDTH-1:0] r_sel;
  logic                 r_proto_err;

  logic [IDX_WIDTH-1:0] w_rr_winner;
  logic                 w_found;
  logic [IDX_WIDTH-1:0] w_winner;
  obi_req_t             w_slave_req;
  logic                 w_hs;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [IDX_WIDTH-1:0] w_head;
  logic [CNT_WIDTH-1:0] w_cnt;

  // (base + off) mod NUM_MASTERS, with base < NUM_MASTERS and off <= NUM_MASTERS
  function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] base,
                                                    input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_MASTERS) begin
      sum = sum - NUM_MASTERS;
    end
    return IDX_WIDTH'(sum);
  endfunction

  // Round-robin scan: first requester at or after the pointer
  always_comb begin
    w_rr_winner = r_rr_ptr;
    w_found     = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && master_req_i[wrap_add(r_rr_ptr, i)].req) begin
        w_found     = 1'b1;
        w_rr_winner = wrap_add(r_rr_ptr, i);
      end
    end
  end

  // A locked selection keeps the slave-side address phase stable until granted
  assign w_winner = r_lock ? r_sel : w_rr_winner;

  // Forward the winner's request, held off while no tracking slot is free
  always_comb begin
    w_slave_req     = master_req_i[w_winner];
    w_slave_req.req = master_req_i[w_winner].req & ~w_full;
  end

  assign slave_req_o = w_slave_req;
  assign w_hs        = w_slave_req.req & slave_resp_i.gnt;
  assign w_pop       = slave_resp_i.rvalid & ~w_empty;

  // Grant to the winner only; response and rdata to the FIFO head only
  always_comb begin
    master_resp_o = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (w_hs && (w_winner == IDX_WIDTH'(i))) begin
        master_resp_o[i].gnt = 1'b1;
      end
      if (w_pop && (w_head == IDX_WIDTH'(i))) begin
        master_resp_o[i].rvalid = 1'b1;
        master_resp_o[i].rdata  = slave_resp_i.rdata;
      end
    end
  end

  // Pointer advance on handshake, lock while a request waits for its grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
      r_lock   <= 1'b0;
      r_sel    <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= wrap_add(w_winner, 1);
      r_lock   <= 1'b0;
    end else if (w_slave_req.req) begin
      r_lock   <= 1'b1;
      r_sel    <= w_winner;
    end else begin
      // A withdrawn request releases the lock so other masters are not starved
      r_lock   <= 1'b0;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_proto_err <= 1'b0;
    end else if (slave_resp_i.rvalid && w_empty) begin
      r_proto_err <= 1'b1;
    end
  end

  ext_obi_resp_route_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_WIDTH)
  ) u_route_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_hs),
    .data_i  (w_winner),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head),
    .cnt_o   (w_cnt)
  );

  assign busy_o      = (w_cnt != '0);
  assign proto_err_o = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_ext_obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_obi_rr_arbiter
// Description : Self-checking bench for ext_obi_rr_arbiter: directed
//               scenarios plus randomized traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_obi_rr_arbiter;
  import ext_obi_rr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int MO = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  obi_req_t  [N-1:0] m_req;
  obi_resp_t [N-1:0] m_resp;
  obi_req_t         s_req;
  obi_resp_t        s_resp;
  logic             busy;
  logic             perr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ext_obi_rr_arbiter #(
    .NUM_MASTERS     (N),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .master_req_i  (m_req),
    .master_resp_o (m_resp),
    .slave_req_o   (s_req),
    .slave_resp_i  (s_resp),
    .busy_o        (busy),
    .proto_err_o   (perr)
  );

  function automatic obi_req_t mk(input logic [31:0] a);
    obi_req_t r;
    r       = '0;
    r.req   = 1'b1;
    r.be    = 4'hF;
    r.addr  = a;
    r.wdata = ~a;
    return r;
  endfunction

  function automatic logic [N-1:0] gnt_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_resp[i].gnt;
    return v;
  endfunction

  function automatic logic [N-1:0] rv_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_resp[i].rvalid;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    m_req  = '0;
    s_resp = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd_or;
    rst_n  = 1'b0;
    m_req  = '0;
    s_resp = '0;
    @(negedge clk);
    rd_or = '0;
    for (int i = 0; i < N; i++) rd_or = rd_or | m_resp[i].rdata;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", perr); end
    checks++; if (s_req.req !== 1'b0) begin errors++; $display("FAIL reset_sreq got %b exp 0", s_req.req); end
    checks++; if (gnt_vec() !== '0) begin errors++; $display("FAIL reset_gnt got %b exp 0", gnt_vec()); end
    checks++; if (rv_vec() !== '0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rv_vec()); end
    checks++; if (rd_or !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rd_or); end
  endtask

  task automatic test_single_master();
    do_reset();
    m_req[2]    = mk(32'h2000);
    s_resp.gnt  = 1'b1;
    @(negedge clk);
    checks++; if (s_req.req !== 1'b1) begin errors++; $display("FAIL single_req got %b exp 1", s_req.req); end
    checks++; if (s_req.addr !== 32'h2000) begin errors++; $display("FAIL single_addr got %h exp 2000", s_req.addr); end
    checks++; if (gnt_vec() !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", gnt_vec()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy0 got %b exp 0", busy); end
    tick();
    m_req[2]     = '0;
    s_resp.gnt   = 1'b0;
    s_resp.rvalid = 1'b1;
    s_resp.rdata = 32'hCAFE0001;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b exp 1", busy); end
    checks++; if (rv_vec() !== 4'b0100) begin errors++; $display("FAIL single_rvalid got %b exp 0100", rv_vec()); end
    checks++; if (m_resp[2].rdata !== 32'hCAFE0001) begin errors++; $display("FAIL single_rdata got %h exp cafe0001", m_resp[2].rdata); end
    tick();
    s_resp = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy2 got %b exp 0", busy); end
    checks++; if (rv_vec() !== '0) begin errors++; $display("FAIL single_rvalid2 got %b exp 0", rv_vec()); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) m_req[i] = mk(32'h1000 * i);
    s_resp.gnt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp = '0;
      exp[c % N] = 1'b1;
      checks++; if (gnt_vec() !== exp) begin errors++; $display("FAIL rr_order cycle %0d got %b exp %b", c, gnt_vec(), exp); end
      tick();
      s_resp.rvalid = 1'b1;
    end
  endtask

  task automatic test_lock();
    do_reset();
    m_req[1] = mk(32'h1100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (s_req.addr !== 32'h1100 || s_req.req !== 1'b1) begin
        errors++; $display("FAIL lock_addr cycle %0d got req %b addr %h exp 1 1100", c, s_req.req, s_req.addr);
      end
      checks++; if (gnt_vec() !== '0) begin errors++; $display("FAIL lock_nognt cycle %0d got %b exp 0", c, gnt_vec()); end
      tick();
      m_req[0] = mk(32'h0004);
    end
    s_resp.gnt = 1'b1;
    @(negedge clk);
    checks++; if (gnt_vec() !== 4'b0010) begin errors++; $display("FAIL lock_m1_first got %b exp 0010", gnt_vec()); end
    tick();
    m_req[1] = '0;
    @(negedge clk);
    checks++; if (gnt_vec() !== 4'b0001) begin errors++; $display("FAIL lock_m0_next got %b exp 0001", gnt_vec()); end
  endtask

  task automatic test_outstanding();
    do_reset();
    m_req[0]   = mk(32'h40);
    s_resp.gnt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (gnt_vec() !== 4'b0001) begin errors++; $display("FAIL out_gnt cycle %0d got %b exp 0001", c, gnt_vec()); end
      tick();
    end
    @(negedge clk);
    checks++; if (s_req.req !== 1'b0) begin errors++; $display("FAIL out_full_req got %b exp 0", s_req.req); end
    checks++; if (gnt_vec() !== '0) begin errors++; $display("FAIL out_full_gnt got %b exp 0", gnt_vec()); end
    tick();
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'h55;
    @(negedge clk);
    checks++; if (s_req.req !== 1'b0) begin errors++; $display("FAIL out_nobypass got %b exp 0", s_req.req); end
    checks++; if (rv_vec() !== 4'b0001) begin errors++; $display("FAIL out_rvalid got %b exp 0001", rv_vec()); end
    tick();
    s_resp.rvalid = 1'b0;
    @(negedge clk);
    checks++; if (s_req.req !== 1'b1 || gnt_vec() !== 4'b0001) begin
      errors++; $display("FAIL out_resume got req %b gnt %b exp 1 0001", s_req.req, gnt_vec());
    end
  endtask

  task automatic test_in_order();
    do_reset();
    s_resp.gnt = 1'b1;
    m_req[3]   = mk(32'h3000);
    @(negedge clk);
    checks++; if (gnt_vec() !== 4'b1000) begin errors++; $display("FAIL order_g3 got %b exp 1000", gnt_vec()); end
    tick();
    m_req[3] = '0;
    m_req[0] = mk(32'h0010);
    @(negedge clk);
    checks++; if (gnt_vec() !== 4'b0001) begin errors++; $display("FAIL order_g0 got %b exp 0001", gnt_vec()); end
    tick();
    m_req[0]      = '0;
    s_resp.gnt    = 1'b0;
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'h33;
    @(negedge clk);
    checks++; if (rv_vec() !== 4'b1000) begin errors++; $display("FAIL order_rv3 got %b exp 1000", rv_vec()); end
    checks++; if (m_resp[3].rdata !== 32'h33) begin errors++; $display("FAIL order_rd3 got %h exp 33", m_resp[3].rdata); end
    checks++; if (m_resp[0].rdata !== 32'h0) begin errors++; $display("FAIL order_rd0_idle got %h exp 0", m_resp[0].rdata); end
    tick();
    s_resp.rdata = 32'h00;
    @(negedge clk);
    checks++; if (rv_vec() !== 4'b0001) begin errors++; $display("FAIL order_rv0 got %b exp 0001", rv_vec()); end
    checks++; if (m_resp[0].rdata !== 32'h0) begin errors++; $display("FAIL order_rd0 got %h exp 0", m_resp[0].rdata); end
    tick();
    s_resp = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL order_drain got %b exp 0", busy); end
  endtask

  task automatic test_errors_reset();
    do_reset();
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'h77;
    @(negedge clk);
    checks++; if (rv_vec() !== '0) begin errors++; $display("FAIL err_drop got %b exp 0", rv_vec()); end
    tick();
    s_resp = '0;
    @(negedge clk);
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", perr); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", perr); end
    tick();
    m_req[1]   = mk(32'h1234);
    s_resp.gnt = 1'b1;
    tick();
    m_req[1]   = '0;
    s_resp     = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_busy_pre got %b exp 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || perr !== 1'b0) begin
      errors++; $display("FAIL err_rst_clear got busy %b perr %b exp 0 0", busy, perr);
    end
    checks++; if (s_req.req !== 1'b0 || gnt_vec() !== '0 || rv_vec() !== '0) begin
      errors++; $display("FAIL err_rst_outs got req %b gnt %b rv %b exp 0", s_req.req, gnt_vec(), rv_vec());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_resp.rvalid = 1'b1;
    @(negedge clk);
    checks++; if (rv_vec() !== '0) begin errors++; $display("FAIL err_late_rv got %b exp 0", rv_vec()); end
    tick();
    s_resp = '0;
    @(negedge clk);
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL err_late_perr got %b exp 1", perr); end
  endtask

  task automatic test_random();
    int      rr;
    bit      lock;
    int      sel;
    int      q[$];
    int      w;
    bit      found;
    bit      exp_req;
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_rv;
    do_reset();
    rr = 0; lock = 0; sel = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Masters keep an ungranted request stable; otherwise decide afresh
      for (int i = 0; i < N; i++) begin
        if (!m_req[i].req || m_resp[i].gnt) begin
          if ($urandom_range(0, 99) < 45) begin
            m_req[i]       = mk($urandom);
            m_req[i].we    = 1'($urandom);
            m_req[i].be    = 4'($urandom);
            m_req[i].wdata = $urandom;
          end else begin
            m_req[i] = '0;
          end
        end
      end
      s_resp.gnt    = ($urandom_range(0, 99) < 60);
      s_resp.rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      s_resp.rdata  = $urandom;
      @(negedge clk);
      if (lock) begin
        w = sel;
      end else begin
        w = rr; found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && m_req[(rr + k) % N].req) begin
            found = 1; w = (rr + k) % N;
          end
        end
      end
      exp_req = m_req[w].req && (q.size() < MO);
      exp_g   = '0;
      if (exp_req && s_resp.gnt) exp_g[w] = 1'b1;
      exp_rv  = '0;
      if (s_resp.rvalid && q.size() > 0) exp_rv[q[0]] = 1'b1;
      checks++; if (s_req.req !== exp_req) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", cyc, s_req.req, exp_req); end
      if (exp_req) begin
        checks++; if (s_req.addr !== m_req[w].addr || s_req.wdata !== m_req[w].wdata) begin
          errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, s_req.addr, m_req[w].addr);
        end
      end
      checks++; if (gnt_vec() !== exp_g) begin errors++; $display("FAIL rnd_gnt cyc %0d got %b exp %b", cyc, gnt_vec(), exp_g); end
      checks++; if (rv_vec() !== exp_rv) begin errors++; $display("FAIL rnd_rvalid cyc %0d got %b exp %b", cyc, rv_vec(), exp_rv); end
      if (exp_rv != '0) begin
        checks++; if (m_resp[q[0]].rdata !== s_resp.rdata) begin
          errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", cyc, m_resp[q[0]].rdata, s_resp.rdata);
        end
      end
      checks++; if (busy !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, busy, q.size() != 0); end
      checks++; if (perr !== 1'b0) begin errors++; $display("FAIL rnd_perr cyc %0d got %b exp 0", cyc, perr); end
      if (exp_rv != '0) void'(q.pop_front());
      if (exp_req && s_resp.gnt) begin
        q.push_back(w);
        rr   = (w + 1) % N;
        lock = 0;
      end else if (exp_req) begin
        lock = 1;
        sel  = w;
      end
      tick();
    end
  endtask

  initial begin
    m_req  = '0;
    s_resp = '0;
    test_reset();
    test_single_master();
    test_round_robin();
    test_lock();
    test_outstanding();
    test_in_order();
    test_errors_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
